// File: rtl/cache_pkg.sv
// Shared types and geometry constants for the data-cache controller and the cache array.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    FILL   = 2'd2,
    WRITE  = 2'd3
  } refill_state_t;

  localparam int CACHE_LENGTH = 8;
  localparam int SET_WIDTH    = 3;
  localparam int TAG_WIDTH    = 27;
  localparam int WORD_OFFSET  = 2;

endpackage

// File: rtl/cache_refill_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // next count: clear wins, increment only below all-ones
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = {WIDTH{1'b0}};
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss refill and write-through controller for the direct-mapped data cache,
// with saturating load hit/miss counters.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  cache_hit,
  output logic                  stall,
  output logic                  cache_we,
  output logic [DATA_WIDTH-1:0] cache_addr,
  output logic [DATA_WIDTH-1:0] cache_wdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  refill_state_t         state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  // holds the store data, or the refill word once mem_ack returns it
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  hit_inc;
  logic                  miss_inc;

  // state and datapath latches
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= {DATA_WIDTH{1'b0}};
      data_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // next state and latch updates
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_we) begin
          addr_d  = req_addr;
          data_d  = req_wdata;
          state_d = WRITE;
        end else if (req_valid && !cache_hit) begin
          addr_d  = req_addr;
          state_d = REFILL;
        end else begin
          state_d = IDLE;
        end
      end
      REFILL: begin
        if (mem_ack) begin
          data_d  = mem_rdata;
          state_d = FILL;
        end else begin
          state_d = REFILL;
        end
      end
      FILL: begin
        state_d = IDLE;
      end
      WRITE: begin
        if (mem_ack) begin
          state_d = IDLE;
        end else begin
          state_d = WRITE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // strobes and stall; only IDLE looks at req_* so mem_req stays purely registered
  always_comb begin
    stall    = 1'b0;
    cache_we = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_we) begin
          stall = 1'b1;
        end else if (req_valid && cache_hit) begin
          hit_inc = 1'b1;
        end else if (req_valid) begin
          stall    = 1'b1;
          miss_inc = 1'b1;
        end else begin
          stall = 1'b0;
        end
      end
      REFILL: begin
        mem_req = 1'b1;
        stall   = 1'b1;
      end
      FILL: begin
        cache_we = 1'b1;
        stall    = 1'b1;
      end
      WRITE: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        stall    = !mem_ack;
        cache_we = mem_ack;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  assign cache_addr  = addr_q;
  assign cache_wdata = data_q;
  assign mem_addr    = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign mem_wdata   = data_q;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .clear (1'b0),
    .count (hit_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .clear (1'b0),
    .count (miss_count)
  );

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: per-transaction expected timelines built from
// the refill/write-through rules, checked every cycle, plus literal checkpoints.
module tb_cache_refill_ctrl;

  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_we, cache_hit, mem_ack;
  logic [DW-1:0] req_addr, req_wdata, mem_rdata;
  logic          stall, cache_we, mem_req, mem_we;
  logic [DW-1:0] cache_addr, cache_wdata, mem_addr, mem_wdata;
  logic [CW-1:0] hit_count, miss_count;

  cache_refill_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .cache_hit(cache_hit),
    .stall(stall), .cache_we(cache_we), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // expected outputs for the current cycle, and the model's counters
  logic          e_stall, e_cwe, e_mreq, e_mwe;
  logic [DW-1:0] e_caddr, e_cwdata, e_maddr, e_mwdata;
  logic [CW-1:0] m_hit, m_miss;
  logic          chk_en = 1'b0;
  int            n_chk = 0, n_fail = 0;
  int            stall_cnt = 0, cwe_cnt = 0, mreq_cnt = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      if (stall === 1'b1) stall_cnt++;
      if (cache_we === 1'b1) cwe_cnt++;
      if (mem_req === 1'b1) mreq_cnt++;
      chk("stall", {31'd0, stall}, {31'd0, e_stall});
      chk("cache_we", {31'd0, cache_we}, {31'd0, e_cwe});
      chk("mem_req", {31'd0, mem_req}, {31'd0, e_mreq});
      chk("mem_we", {31'd0, mem_we}, {31'd0, e_mwe});
      if (e_mreq) chk("mem_addr", mem_addr, e_maddr);
      if (e_mreq && e_mwe) chk("mem_wdata", mem_wdata, e_mwdata);
      if (e_cwe) begin
        chk("cache_addr", cache_addr, e_caddr);
        chk("cache_wdata", cache_wdata, e_cwdata);
      end
      chk("hit_count", {24'd0, hit_count}, {24'd0, m_hit});
      chk("miss_count", {24'd0, miss_count}, {24'd0, m_miss});
    end
  end

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 8'd1;
  endfunction

  // advance one clock; counter events of this cycle take effect at the edge
  task automatic cycle(input logic h_ev, input logic m_ev);
    @(posedge clk);
    #1;
    if (rst) begin
      m_hit  = 8'd0;
      m_miss = 8'd0;
    end else begin
      if (h_ev) m_hit = sat_inc(m_hit);
      if (m_ev) m_miss = sat_inc(m_miss);
    end
  endtask

  task automatic set_idle();
    req_valid = 1'b0; req_we = 1'b0; cache_hit = 1'b0; mem_ack = 1'b0;
    e_stall = 1'b0; e_cwe = 1'b0; e_mreq = 1'b0; e_mwe = 1'b0;
  endtask

  task automatic clr_cnts();
    stall_cnt = 0; cwe_cnt = 0; mreq_cnt = 0;
  endtask

  // load hit held for n cycles: no stall, one hit per cycle
  task automatic load_hits(input logic [DW-1:0] a, input int n);
    set_idle();
    req_valid = 1'b1; req_addr = a; cache_hit = 1'b1;
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0);
  endtask

  // load miss with latency lat: IDLE, lat REFILL cycles, FILL, then the hitting re-lookup
  task automatic load_miss(input logic [DW-1:0] a, input int lat, input logic [DW-1:0] rd);
    set_idle();
    req_valid = 1'b1; req_addr = a; e_stall = 1'b1;
    cycle(1'b0, 1'b1);
    e_mreq = 1'b1; e_maddr = a & ~32'd3;
    for (int i = 1; i <= lat; i++) begin
      mem_ack   = (i == lat);
      mem_rdata = (i == lat) ? rd : (32'h0BAD_0000 | i);
      cycle(1'b0, 1'b0);
    end
    mem_ack = 1'b0; e_mreq = 1'b0;
    e_cwe = 1'b1; e_caddr = a; e_cwdata = rd;
    cycle(1'b0, 1'b0);
    e_cwe = 1'b0; e_stall = 1'b0; cache_hit = 1'b1;
    cycle(1'b1, 1'b0);
  endtask

  // store with latency lat: IDLE, then lat WRITE cycles; stall drops in the ack cycle
  task automatic store(input logic [DW-1:0] a, input logic [DW-1:0] d, input int lat);
    set_idle();
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; e_stall = 1'b1;
    cycle(1'b0, 1'b0);
    e_mreq = 1'b1; e_mwe = 1'b1; e_maddr = a & ~32'd3; e_mwdata = d;
    e_caddr = a; e_cwdata = d;
    for (int i = 1; i <= lat; i++) begin
      mem_ack = (i == lat);
      e_stall = (i != lat);
      e_cwe   = (i == lat);
      cycle(1'b0, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; req_addr = '0; req_wdata = '0; mem_rdata = '0;
    m_hit = 8'd0; m_miss = 8'd0;
    set_idle();
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_cache_we", {31'd0, cache_we}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_cache_addr", cache_addr, 32'd0);
    chk("rst_cache_wdata", cache_wdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_hits", {24'd0, hit_count}, 32'd0);
    chk("rst_misses", {24'd0, miss_count}, 32'd0);
    chk_en = 1'b1;
    cycle(1'b0, 1'b0);

    // miss at 0x40, latency 3
    clr_cnts();
    load_miss(32'h0000_0040, 3, 32'hDEAD_BEEF);
    set_idle();
    @(negedge clk);
    chk("miss_stall_cycles", stall_cnt, 32'd5);
    chk("miss_fill_pulses", cwe_cnt, 32'd1);
    chk("miss_cnt_lit", {24'd0, miss_count}, 32'd1);
    chk("hit_cnt_lit", {24'd0, hit_count}, 32'd1);
    cycle(1'b0, 1'b0);

    // sustained hits
    clr_cnts();
    load_hits(32'h0000_0080, 4);
    set_idle();
    @(negedge clk);
    chk("hits_no_stall", stall_cnt, 32'd0);
    chk("hits_no_memreq", mreq_cnt, 32'd0);
    chk("hits_cnt_lit", {24'd0, hit_count}, 32'd5);
    cycle(1'b0, 1'b0);

    // store latency 2, followed immediately by a load hit
    clr_cnts();
    store(32'h0000_0104, 32'h1234_5678, 2);
    load_hits(32'h0000_0040, 1);
    set_idle();
    @(negedge clk);
    chk("store_stall_cycles", stall_cnt, 32'd2);
    chk("store_memreq_cycles", mreq_cnt, 32'd2);
    chk("store_cache_we", cwe_cnt, 32'd1);
    cycle(1'b0, 1'b0);

    // miss with ack in the first memory cycle
    clr_cnts();
    load_miss(32'h0000_0200, 1, 32'hCAFE_F00D);
    set_idle();
    @(negedge clk);
    chk("l1_stall_cycles", stall_cnt, 32'd3);
    cycle(1'b0, 1'b0);

    // reset in the second refill cycle
    clr_cnts();
    req_valid = 1'b1; req_addr = 32'h0000_0300; e_stall = 1'b1;
    cycle(1'b0, 1'b1);
    e_mreq = 1'b1; e_maddr = 32'h0000_0300;
    cycle(1'b0, 1'b0);
    rst = 1'b1;
    cycle(1'b0, 1'b0);
    rst = 1'b0;
    set_idle();
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    mem_ack = 1'b0;
    load_hits(32'h0000_0040, 1);
    set_idle();
    @(negedge clk);
    chk("rst_abandon_no_fill", cwe_cnt, 32'd0);
    chk("rst_abandon_miss", {24'd0, miss_count}, 32'd0);
    chk("rst_abandon_hit", {24'd0, hit_count}, 32'd1);
    cycle(1'b0, 1'b0);

    // saturation
    rst = 1'b1;
    cycle(1'b0, 1'b0);
    rst = 1'b0;
    load_hits(32'h0000_0080, 254);
    set_idle();
    @(negedge clk);
    chk("sat_pre", {24'd0, hit_count}, 32'd254);
    load_hits(32'h0000_0080, 3);
    set_idle();
    @(negedge clk);
    chk("sat_hold", {24'd0, hit_count}, 32'd255);
    cycle(1'b0, 1'b0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
